// File: rtl/alu_issue_unit_pkg.sv
// alu_issue_unit_pkg
//   Shared definitions for the ALU issue unit. It holds the 4-bit ALU opcode
//   encodings driven onto alu_op, the cmd_class and funct3 field values used
//   by the decoder, and the issue FSM state encoding.
package alu_issue_unit_pkg;

    // ALU opcode encodings (alu_op)
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // cmd_class values
    localparam logic [1:0] CLASS_R   = 2'b00;
    localparam logic [1:0] CLASS_I   = 2'b01;
    localparam logic [1:0] CLASS_BR  = 2'b10;
    localparam logic [1:0] CLASS_ILL = 2'b11;

    // funct3 values; arithmetic and branch classes reuse 000
    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_NOR = 3'b101;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    // Issue FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_issue_unit_decoder.sv
// alu_op_decoder
//   Purely combinational decode of (cmd_class, funct3, funct7b5).
//   Ports:
//     cmd_class, funct3, funct7b5 : decoded-instruction fields
//     alu_op     : ALU opcode to issue (ALU_AND when illegal)
//     use_imm    : operand B comes from the immediate (I-type)
//     is_arith   : non-branch ADD/SUB; the only ops whose overflow is reported
//     is_branch  : branch compare (SUB)
//     branch_ne  : branch taken on not-equal (BNE)
//     illegal    : encoding not supported; all other outputs forced to 0
module alu_op_decoder
    import alu_issue_unit_pkg::*;
(
    input  logic [1:0] cmd_class,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [3:0] alu_op,
    output logic       use_imm,
    output logic       is_arith,
    output logic       is_branch,
    output logic       branch_ne,
    output logic       illegal
);

    always_comb begin
        alu_op    = ALU_AND;
        use_imm   = 1'b0;
        is_arith  = 1'b0;
        is_branch = 1'b0;
        branch_ne = 1'b0;
        illegal   = 1'b0;
        case (cmd_class)
            CLASS_R: begin
                case (funct3)
                    F3_ADD: begin
                        alu_op   = funct7b5 ? ALU_SUB : ALU_ADD;
                        is_arith = 1'b1;
                    end
                    F3_AND: alu_op = ALU_AND;
                    F3_OR:  alu_op = ALU_OR;
                    F3_XOR: alu_op = ALU_XOR;
                    F3_SLT: alu_op = ALU_SLT;
                    F3_NOR: begin
                        if (funct7b5) alu_op = ALU_NOR;
                        else          illegal = 1'b1;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            CLASS_I: begin
                use_imm = 1'b1;
                case (funct3)
                    F3_ADD: begin
                        alu_op   = ALU_ADD;
                        is_arith = 1'b1;
                    end
                    F3_AND: alu_op = ALU_AND;
                    F3_OR:  alu_op = ALU_OR;
                    F3_XOR: alu_op = ALU_XOR;
                    F3_SLT: alu_op = ALU_SLT;
                    default: illegal = 1'b1;
                endcase
            end
            CLASS_BR: begin
                alu_op    = ALU_SUB;
                is_branch = 1'b1;
                case (funct3)
                    F3_BEQ:  branch_ne = 1'b0;
                    F3_BNE:  branch_ne = 1'b1;
                    default: illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase

        // An illegal command issues a harmless AND of zeros with no side flags.
        if (illegal) begin
            alu_op    = ALU_AND;
            use_imm   = 1'b0;
            is_arith  = 1'b0;
            is_branch = 1'b0;
            branch_ne = 1'b0;
        end
    end

endmodule

// File: rtl/alu_issue_unit.sv
// alu_issue_unit
//   Issue side of the 4-bit alu_op ALU interface. Accepts a decoded
//   instruction, registers operands/opcode, lets the external combinational
//   ALU evaluate for one cycle (EXEC), captures its outputs into a result
//   register (DONE) and hands that to writeback/branch-resolve.
//
//   Handshakes: a transfer happens on a rising edge where valid and ready are
//   both 1. cmd_valid/cmd_* must be held by the initiator until accepted;
//   res_valid/res_* are held stable until res_ready is seen.
//
//   Ports:
//     clk, rst                   : clock, async active-high reset
//     cmd_valid/cmd_ready        : command handshake
//     cmd_class/funct3/funct7b5  : decode fields
//     cmd_a, cmd_b, cmd_imm      : operand sources
//     alu_operand_a/b, alu_op    : registered drive to the ALU
//     alu_result/zero/overflow   : combinational ALU response
//     res_valid/res_ready        : result handshake
//     res_data/zero/ovf/taken/illegal : captured result fields
//     ovf_sticky, ovf_clear      : accumulated overflow flag and its clear
//     op_count                   : count of completed result handshakes
//   The FSM state is held in state_q (type state_e) for checkers.
module alu_issue_unit
    import alu_issue_unit_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ALU_OP_WIDTH = 4,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_class,
    input  logic [2:0]              cmd_funct3,
    input  logic                    cmd_funct7b5,
    input  logic [DATA_WIDTH-1:0]   cmd_a,
    input  logic [DATA_WIDTH-1:0]   cmd_b,
    input  logic [DATA_WIDTH-1:0]   cmd_imm,
    output logic [DATA_WIDTH-1:0]   alu_operand_a,
    output logic [DATA_WIDTH-1:0]   alu_operand_b,
    output logic [ALU_OP_WIDTH-1:0] alu_op,
    input  logic [DATA_WIDTH-1:0]   alu_result,
    input  logic                    alu_zero,
    input  logic                    alu_overflow,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [DATA_WIDTH-1:0]   res_data,
    output logic                    res_zero,
    output logic                    res_ovf,
    output logic                    res_taken,
    output logic                    res_illegal,
    output logic                    ovf_sticky,
    input  logic                    ovf_clear,
    output logic [CNT_WIDTH-1:0]    op_count
);

    // Decoder outputs
    logic [3:0] dec_alu_op;
    logic       dec_use_imm;
    logic       dec_is_arith;
    logic       dec_is_branch;
    logic       dec_branch_ne;
    logic       dec_illegal;

    alu_op_decoder u_decoder (
        .cmd_class (cmd_class),
        .funct3    (cmd_funct3),
        .funct7b5  (cmd_funct7b5),
        .alu_op    (dec_alu_op),
        .use_imm   (dec_use_imm),
        .is_arith  (dec_is_arith),
        .is_branch (dec_is_branch),
        .branch_ne (dec_branch_ne),
        .illegal   (dec_illegal)
    );

    // State and registers
    state_e                  state_q,       state_d;
    logic [ALU_OP_WIDTH-1:0] op_q,          op_d;
    logic [DATA_WIDTH-1:0]   opa_q,         opa_d;
    logic [DATA_WIDTH-1:0]   opb_q,         opb_d;
    logic                    arith_q,       arith_d;
    logic                    branch_q,      branch_d;
    logic                    bne_q,         bne_d;
    logic                    illegal_q,     illegal_d;
    logic [DATA_WIDTH-1:0]   res_data_q,    res_data_d;
    logic                    res_zero_q,    res_zero_d;
    logic                    res_ovf_q,     res_ovf_d;
    logic                    res_taken_q,   res_taken_d;
    logic                    res_illegal_q, res_illegal_d;
    logic                    ovf_sticky_q,  ovf_sticky_d;
    logic [CNT_WIDTH-1:0]    op_count_q,    op_count_d;

    logic accept;
    logic res_hs;
    logic cap_ovf;
    logic cap_taken;

    // A result leaving DONE frees the unit in the same cycle, so a waiting
    // command can be accepted back-to-back with the result handshake.
    assign res_hs    = (state_q == ST_DONE) && res_ready;
    assign cmd_ready = (state_q == ST_IDLE) || res_hs;
    assign accept    = cmd_valid && cmd_ready;

    // Overflow is only meaningful for non-branch ADD/SUB; branch compares
    // also use SUB but must not report it.
    assign cap_ovf   = arith_q && alu_overflow;
    assign cap_taken = branch_q && (bne_q ? !alu_zero : alu_zero);

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        opa_d         = opa_q;
        opb_d         = opb_q;
        arith_d       = arith_q;
        branch_d      = branch_q;
        bne_d         = bne_q;
        illegal_d     = illegal_q;
        res_data_d    = res_data_q;
        res_zero_d    = res_zero_q;
        res_ovf_d     = res_ovf_q;
        res_taken_d   = res_taken_q;
        res_illegal_d = res_illegal_q;
        ovf_sticky_d  = ovf_sticky_q;
        op_count_d    = op_count_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (res_ready) state_d = accept ? ST_EXEC : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (accept) begin
            op_d      = ALU_OP_WIDTH'(dec_alu_op);
            opa_d     = dec_illegal ? '0 : cmd_a;
            opb_d     = dec_illegal ? '0 : (dec_use_imm ? cmd_imm : cmd_b);
            arith_d   = dec_is_arith;
            branch_d  = dec_is_branch;
            bne_d     = dec_branch_ne;
            illegal_d = dec_illegal;
        end

        if (state_q == ST_EXEC) begin
            res_data_d    = illegal_q ? '0 : alu_result;
            res_zero_d    = alu_zero;
            res_ovf_d     = cap_ovf;
            res_taken_d   = cap_taken;
            res_illegal_d = illegal_q;
        end

        // A new overflow capture takes priority over a coincident clear.
        if ((state_q == ST_EXEC) && cap_ovf) begin
            ovf_sticky_d = 1'b1;
        end else if (ovf_clear) begin
            ovf_sticky_d = 1'b0;
        end

        if (res_hs) begin
            op_count_d = op_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            op_q          <= '0;
            opa_q         <= '0;
            opb_q         <= '0;
            arith_q       <= 1'b0;
            branch_q      <= 1'b0;
            bne_q         <= 1'b0;
            illegal_q     <= 1'b0;
            res_data_q    <= '0;
            res_zero_q    <= 1'b0;
            res_ovf_q     <= 1'b0;
            res_taken_q   <= 1'b0;
            res_illegal_q <= 1'b0;
            ovf_sticky_q  <= 1'b0;
            op_count_q    <= '0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            opa_q         <= opa_d;
            opb_q         <= opb_d;
            arith_q       <= arith_d;
            branch_q      <= branch_d;
            bne_q         <= bne_d;
            illegal_q     <= illegal_d;
            res_data_q    <= res_data_d;
            res_zero_q    <= res_zero_d;
            res_ovf_q     <= res_ovf_d;
            res_taken_q   <= res_taken_d;
            res_illegal_q <= res_illegal_d;
            ovf_sticky_q  <= ovf_sticky_d;
            op_count_q    <= op_count_d;
        end
    end

    assign alu_op        = op_q;
    assign alu_operand_a = opa_q;
    assign alu_operand_b = opb_q;
    assign res_valid     = (state_q == ST_DONE);
    assign res_data      = res_data_q;
    assign res_zero      = res_zero_q;
    assign res_ovf       = res_ovf_q;
    assign res_taken     = res_taken_q;
    assign res_illegal   = res_illegal_q;
    assign ovf_sticky    = ovf_sticky_q;
    assign op_count      = op_count_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// tb_alu_issue_unit
//   Bench for alu_issue_unit: an external ALU is modelled here, expected
//   results come from instruction semantics (sums, compares, equality).
module tb_alu_issue_unit;

    localparam longint S_MAX = 64'sh7FFF_FFFF;
    localparam longint S_MIN = -64'sh8000_0000;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_class;
    logic [2:0]  cmd_funct3;
    logic        cmd_funct7b5;
    logic [31:0] cmd_a, cmd_b, cmd_imm;
    logic [31:0] alu_operand_a, alu_operand_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;
    logic        alu_zero, alu_overflow;
    logic        res_valid, res_ready;
    logic [31:0] res_data;
    logic        res_zero, res_ovf, res_taken, res_illegal;
    logic        ovf_sticky, ovf_clear;
    logic [15:0] op_count;

    alu_issue_unit #(
        .DATA_WIDTH   (32),
        .ALU_OP_WIDTH (4),
        .CNT_WIDTH    (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_class     (cmd_class),
        .cmd_funct3    (cmd_funct3),
        .cmd_funct7b5  (cmd_funct7b5),
        .cmd_a         (cmd_a),
        .cmd_b         (cmd_b),
        .cmd_imm       (cmd_imm),
        .alu_operand_a (alu_operand_a),
        .alu_operand_b (alu_operand_b),
        .alu_op        (alu_op),
        .alu_result    (alu_result),
        .alu_zero      (alu_zero),
        .alu_overflow  (alu_overflow),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .res_zero      (res_zero),
        .res_ovf       (res_ovf),
        .res_taken     (res_taken),
        .res_illegal   (res_illegal),
        .ovf_sticky    (ovf_sticky),
        .ovf_clear     (ovf_clear),
        .op_count      (op_count)
    );

    // ---------------- external ALU ----------------
    // Reports overflow=1 for every non-ADD/SUB op so masking is exercised.
    logic [31:0] env_r;
    logic        env_ovf;
    always_comb begin
        env_r   = 32'h0;
        env_ovf = 1'b1;
        case (alu_op)
            4'b0000: env_r = alu_operand_a & alu_operand_b;
            4'b0001: env_r = alu_operand_a | alu_operand_b;
            4'b0010: begin
                env_r   = alu_operand_a + alu_operand_b;
                env_ovf = (alu_operand_a[31] == alu_operand_b[31]) && (env_r[31] != alu_operand_a[31]);
            end
            4'b0100: env_r = alu_operand_a ^ alu_operand_b;
            4'b0110: begin
                env_r   = alu_operand_a - alu_operand_b;
                env_ovf = (alu_operand_a[31] != alu_operand_b[31]) && (env_r[31] != alu_operand_a[31]);
            end
            4'b0111: env_r = {31'b0, $signed(alu_operand_a) < $signed(alu_operand_b)};
            4'b1100: env_r = ~(alu_operand_a | alu_operand_b);
            default: env_r = 32'hDEAD_BEEF;
        endcase
    end
    assign alu_result   = env_r;
    assign alu_zero     = (env_r == 32'h0);
    assign alu_overflow = env_ovf;

    // ---------------- scoreboard / reference ----------------
    typedef struct packed {
        logic [31:0] data;
        logic [31:0] opa;
        logic [31:0] opb;
        logic        zero;
        logic        ovf;
        logic        taken;
        logic        ill;
    } exp_t;

    int n_checks = 0;
    int n_fails  = 0;
    int exp_count = 0;
    bit exp_sticky = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic sovf(input longint s);
        return (s > S_MAX) || (s < S_MIN);
    endfunction

    // Semantics of the command as an instruction, independent of encodings.
    function automatic exp_t model(input logic [1:0] cls, input logic [2:0] f3, input logic f7,
                                   input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
        exp_t        e;
        logic [31:0] y;
        logic [31:0] rhs;
        bit          ok;
        longint      sa, sr;
        e   = '0;
        y   = 32'h0;
        ok  = 1'b1;
        rhs = (cls == 2'd1) ? imm : b;
        sa  = longint'($signed(a));
        sr  = longint'($signed(rhs));
        if (cls == 2'd3) begin
            ok = 1'b0;
        end else if (cls == 2'd2) begin
            if (f3 == 3'd0 || f3 == 3'd1) begin
                y       = a - b;
                e.taken = (f3 == 3'd0) ? (a == b) : (a != b);
            end else begin
                ok = 1'b0;
            end
        end else begin
            case (f3)
                3'd0: begin
                    if (cls == 2'd0 && f7) begin
                        y     = a - rhs;
                        e.ovf = sovf(sa - sr);
                    end else begin
                        y     = a + rhs;
                        e.ovf = sovf(sa + sr);
                    end
                end
                3'd7: y = a & rhs;
                3'd6: y = a | rhs;
                3'd4: y = a ^ rhs;
                3'd2: y = (sa < sr) ? 32'd1 : 32'd0;
                3'd5: begin
                    if (cls == 2'd0 && f7) y = ~(a | rhs);
                    else ok = 1'b0;
                end
                default: ok = 1'b0;
            endcase
        end
        if (!ok) begin
            e      = '0;
            e.ill  = 1'b1;
            e.zero = 1'b1;
        end else begin
            e.data = y;
            e.zero = (y == 32'h0);
            e.opa  = a;
            e.opb  = rhs;
        end
        return e;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_cmd(input logic [1:0] cls, input logic [2:0] f3, input logic f7,
                             input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
        cmd_valid    = 1'b1;
        cmd_class    = cls;
        cmd_funct3   = f3;
        cmd_funct7b5 = f7;
        cmd_a        = a;
        cmd_b        = b;
        cmd_imm      = imm;
    endtask

    task automatic scramble_cmd();
        cmd_valid    = 1'b0;
        cmd_class    = 2'($urandom_range(0, 3));
        cmd_funct3   = 3'($urandom_range(0, 7));
        cmd_funct7b5 = 1'($urandom_range(0, 1));
        cmd_a        = $urandom();
        cmd_b        = $urandom();
        cmd_imm      = $urandom();
    endtask

    task automatic check_result(input string tag, input exp_t e);
        chk({tag, ".res_valid"},   {31'b0, res_valid},   32'd1);
        chk({tag, ".res_data"},    res_data,             e.data);
        chk({tag, ".res_zero"},    {31'b0, res_zero},    {31'b0, e.zero});
        chk({tag, ".res_ovf"},     {31'b0, res_ovf},     {31'b0, e.ovf});
        chk({tag, ".res_taken"},   {31'b0, res_taken},   {31'b0, e.taken});
        chk({tag, ".res_illegal"}, {31'b0, res_illegal}, {31'b0, e.ill});
        chk({tag, ".ovf_sticky"},  {31'b0, ovf_sticky},  {31'b0, exp_sticky});
    endtask

    // Called #1 after an edge with the unit idle; returns idle, #1 after an edge.
    task automatic run_cmd(input string tag, input logic [1:0] cls, input logic [2:0] f3, input logic f7,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                           input int hold_cycles);
        exp_t e;
        int   guard;
        e = model(cls, f3, f7, a, b, imm);
        drive_cmd(cls, f3, f7, a, b, imm);
        guard = 0;
        while (!cmd_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        chk({tag, ".cmd_ready"}, {31'b0, cmd_ready}, 32'd1);
        @(posedge clk); #1;
        scramble_cmd();
        // EXEC: operands come from registers, not from the (now changed) cmd bus
        chk({tag, ".exec_valid"}, {31'b0, res_valid}, 32'd0);
        chk({tag, ".exec_ready"}, {31'b0, cmd_ready}, 32'd0);
        chk({tag, ".operand_a"},  alu_operand_a, e.opa);
        chk({tag, ".operand_b"},  alu_operand_b, e.opb);
        @(posedge clk); #1;
        if (e.ovf) exp_sticky = 1'b1;
        check_result(tag, e);
        for (int i = 0; i < hold_cycles; i++) begin
            @(posedge clk); #1;
            chk({tag, ".hold_valid"}, {31'b0, res_valid}, 32'd1);
            chk({tag, ".hold_data"},  res_data, e.data);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        exp_count++;
        chk({tag, ".op_count"},   {16'b0, op_count}, 32'(exp_count[15:0]));
        chk({tag, ".idle_valid"}, {31'b0, res_valid}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".res_valid"},   {31'b0, res_valid},   32'd0);
        chk({tag, ".res_data"},    res_data,             32'd0);
        chk({tag, ".res_zero"},    {31'b0, res_zero},    32'd0);
        chk({tag, ".res_ovf"},     {31'b0, res_ovf},     32'd0);
        chk({tag, ".res_taken"},   {31'b0, res_taken},   32'd0);
        chk({tag, ".res_illegal"}, {31'b0, res_illegal}, 32'd0);
        chk({tag, ".ovf_sticky"},  {31'b0, ovf_sticky},  32'd0);
        chk({tag, ".op_count"},    {16'b0, op_count},    32'd0);
        chk({tag, ".alu_op"},      {28'b0, alu_op},      32'd0);
        chk({tag, ".operand_a"},   alu_operand_a,        32'd0);
        chk({tag, ".operand_b"},   alu_operand_b,        32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    logic [31:0] specials [5];
    exp_t        e1, e2;
    logic [31:0] ra, rb, ri;

    initial begin
        specials[0] = 32'h0;
        specials[1] = 32'h1;
        specials[2] = 32'h7FFF_FFFF;
        specials[3] = 32'h8000_0000;
        specials[4] = 32'hFFFF_FFFF;

        rst       = 1'b1;
        res_ready = 1'b0;
        ovf_clear = 1'b0;
        scramble_cmd();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_reset.cmd_ready", {31'b0, cmd_ready}, 32'd1);

        // Arithmetic, overflow and flags
        run_cmd("r_add_ovf", 2'd0, 3'd0, 1'b0, 32'h7FFF_FFFF, 32'h1, 32'h0, 0);
        run_cmd("r_sub_zero", 2'd0, 3'd0, 1'b1, 32'd5, 32'd5, 32'h0, 1);
        run_cmd("i_slt",      2'd1, 3'd2, 1'b0, 32'hFFFF_FFFF, 32'h0, 32'h1, 0);
        run_cmd("r_nor",      2'd0, 3'd5, 1'b1, 32'h0F0F_0000, 32'h0000_00F0, 32'h0, 0);
        run_cmd("i_xor",      2'd1, 3'd4, 1'b1, 32'hA5A5_A5A5, 32'h1111_1111, 32'hFFFF_0000, 0);
        // Branches; the last one makes the ALU report overflow, which must be masked
        run_cmd("br_bne_eq",  2'd2, 3'd1, 1'b0, 32'h1234, 32'h1234, 32'h0, 0);
        run_cmd("br_beq_eq",  2'd2, 3'd0, 1'b0, 32'h1234, 32'h1234, 32'h0, 0);
        run_cmd("br_beq_ovf", 2'd2, 3'd0, 1'b0, 32'h8000_0000, 32'h1, 32'h0, 0);
        run_cmd("r_and_mask", 2'd0, 3'd7, 1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 32'h0, 0);
        // Illegal encodings
        run_cmd("ill_class3", 2'd3, 3'd0, 1'b0, 32'hDEAD_0001, 32'h5, 32'h7, 0);
        run_cmd("ill_r_f3_1", 2'd0, 3'd1, 1'b0, 32'h1, 32'h2, 32'h3, 0);
        run_cmd("ill_i_f3_5", 2'd1, 3'd5, 1'b1, 32'h1, 32'h2, 32'h3, 0);
        run_cmd("ill_br_f3_4", 2'd2, 3'd4, 1'b0, 32'h9, 32'h9, 32'h0, 0);

        // Clear the sticky flag with no capture in flight
        ovf_clear = 1'b1;
        @(posedge clk); #1;
        ovf_clear = 1'b0;
        exp_sticky = 1'b0;
        chk("ovf_clear", {31'b0, ovf_sticky}, 32'd0);

        // Held result with a pending command, then back-to-back accept
        e1 = model(2'd0, 3'd0, 1'b0, 32'd3, 32'd4, 32'd0);
        e2 = model(2'd0, 3'd0, 1'b0, 32'h7FFF_FFFF, 32'd1, 32'd0);
        drive_cmd(2'd0, 3'd0, 1'b0, 32'd3, 32'd4, 32'd0);
        chk("b2b.first_ready", {31'b0, cmd_ready}, 32'd1);
        @(posedge clk); #1;
        drive_cmd(2'd0, 3'd0, 1'b0, 32'h7FFF_FFFF, 32'd1, 32'd0);
        @(posedge clk); #1;
        check_result("b2b.first", e1);
        for (int i = 0; i < 3; i++) begin
            chk("hold.cmd_ready", {31'b0, cmd_ready}, 32'd0);
            chk("hold.res_valid", {31'b0, res_valid}, 32'd1);
            chk("hold.res_data",  res_data, e1.data);
            chk("hold.res_zero",  {31'b0, res_zero}, {31'b0, e1.zero});
            chk("hold.op_count",  {16'b0, op_count}, 32'(exp_count[15:0]));
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        #1;
        chk("b2b.release_ready", {31'b0, cmd_ready}, 32'd1);
        @(posedge clk); #1;
        res_ready = 1'b0;
        scramble_cmd();
        exp_count++;
        chk("b2b.op_count",   {16'b0, op_count}, 32'(exp_count[15:0]));
        chk("b2b.exec_valid", {31'b0, res_valid}, 32'd0);
        chk("b2b.operand_a",  alu_operand_a, e2.opa);
        // Clear coincides with the overflow capture edge: the set wins
        ovf_clear = 1'b1;
        @(posedge clk); #1;
        ovf_clear = 1'b0;
        exp_sticky = 1'b1;
        check_result("b2b.second", e2);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        exp_count++;
        chk("b2b.op_count2", {16'b0, op_count}, 32'(exp_count[15:0]));

        // Asynchronous reset while a command is in EXEC
        drive_cmd(2'd0, 3'd0, 1'b0, 32'h7FFF_FFFF, 32'd1, 32'd0);
        @(posedge clk); #1;
        scramble_cmd();
        chk("rst_exec.pre_valid", {31'b0, res_valid}, 32'd0);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_exec");
        @(posedge clk); #1;
        rst = 1'b0;
        exp_count  = 0;
        exp_sticky = 1'b0;
        @(posedge clk); #1;
        chk("rst_exec.no_result", {31'b0, res_valid}, 32'd0);
        run_cmd("after_rst", 2'd1, 3'd0, 1'b0, 32'd100, 32'd0, 32'hFFFF_FFFF, 0);

        // Randomized commands against the reference model
        for (int n = 0; n < 60; n++) begin
            ra = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom();
            rb = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom();
            ri = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom();
            if ($urandom_range(0, 3) == 0) rb = ra;
            run_cmd("rand", 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    ra, rb, ri, int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/alu_issue_unit.md
Name: alu_issue_unit

Overview:
- Initiator/consumer end of the 4-bit alu_op ALU interface.
- Accepts decoded-instruction commands over a valid/ready handshake and decodes class/funct fields into alu_op.
- Registers operands and drives the combinational ALU for one cycle, then captures alu_result, zero_flag and overflow_flag into a result register with its own valid/ready handshake.
- Sits between the decode stage and writeback/branch-resolve logic.

Parameters:
DATA_WIDTH, 32, operand/result width
ALU_OP_WIDTH, 4, ALU opcode width
CNT_WIDTH, 16, width of completed-operation counter

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  unit can accept command this cycle
cmd_class  in  2  00 R-type, 01 I-type arith, 10 branch, 11 illegal
cmd_funct3  in  3  operation select
cmd_funct7b5  in  1  R-type modifier bit
cmd_a  in  DATA_WIDTH  rs1 value
cmd_b  in  DATA_WIDTH  rs2 value (R-type, branch)
cmd_imm  in  DATA_WIDTH  sign-extended immediate (I-type)
alu_operand_a  out  DATA_WIDTH  to ALU
alu_operand_b  out  DATA_WIDTH  to ALU
alu_op  out  ALU_OP_WIDTH  to ALU
alu_result  in  DATA_WIDTH  from ALU
alu_zero  in  1  from ALU
alu_overflow  in  1  from ALU
res_valid  out  1  result held
res_ready  in  1  consumer takes result
res_data  out  DATA_WIDTH  captured result
res_zero  out  1  captured zero flag
res_ovf  out  1  masked overflow
res_taken  out  1  branch outcome
res_illegal  out  1  command was illegal
ovf_sticky  out  1  any overflow since last clear
ovf_clear  in  1  clears ovf_sticky
op_count  out  CNT_WIDTH  completed result handshakes

Behaviour:
- Clock clk, reset rst: one clock; reset asynchronous, active-high.
- Reset values: state IDLE, all res_* 0, ovf_sticky 0, op_count 0, operand/op registers 0.
- alu_operand_a, alu_operand_b and alu_op come straight from registers; no combinational path from cmd_* to the ALU.
- Decode, ALU encoding AND 0000, OR 0001, ADD 0010, XOR 0100, SUB 0110, SLT 0111, NOR 1100:
  - R-type (B=cmd_b): f3 000 → ADD (f7b5=0) or SUB (f7b5=1); 111 AND; 110 OR; 100 XOR; 010 SLT; 101 with f7b5=1 → NOR; all else illegal.
  - I-type (B=cmd_imm): 000 ADD, 111 AND, 110 OR, 100 XOR, 010 SLT; all else illegal.
  - Branch (B=cmd_b, op SUB): f3 000 BEQ, 001 BNE; all else illegal.
  - Class 11: always illegal.
- Illegal commands: register alu_op=0000 and operands=0.
- FSM IDLE/EXEC/DONE:
  - cmd_ready = (IDLE) or (DONE and res_ready).
  - Accept (cmd_valid & cmd_ready): load op/operand/kind registers, go to EXEC.
  - EXEC (one cycle): ALU driven from registers. At the edge, capture res_data (alu_result, or 0 if illegal), res_zero=alu_zero, and res_illegal; go to DONE.
  - res_ovf = alu_overflow only for ADD/SUB non-branch, else 0.
  - res_taken = alu_zero (BEQ), ~alu_zero (BNE), else 0.
  - DONE: res_valid=1. All res_* stable while res_ready=0.
  - On res_ready: go to EXEC if a new command is accepted in the same cycle, else IDLE.
- Latency: accept edge to res_valid = 2 cycles. Peak throughput 1 result per 2 cycles.
- ovf_sticky: set at EXEC capture when res_ovf is 1; cleared by ovf_clear. Simultaneous set and clear → set wins.
- op_count: increments on each res_valid & res_ready; wraps modulo 2^CNT_WIDTH.
- cmd_valid while not ready is ignored; the initiator must hold it.
- rst mid-EXEC or mid-DONE: immediate return to reset values; in-flight result discarded, not counted.

Decomposition:
- Shared package holds:
  - ALU opcode constants (ALU_AND, ALU_OR, ALU_ADD, ALU_XOR, ALU_SUB, ALU_SLT, ALU_NOR).
  - cmd_class constants.
  - funct3 constants.
  - FSM state encoding.
- Sub-module alu_op_decoder: combinational; takes (class, funct3, funct7b5) and produces alu_op, use_imm, is_arith, is_branch, branch_ne, illegal.

Test Plan:
- R ADD, a=0x7FFFFFFF, b=1 → res_data 0x80000000, res_ovf 1, ovf_sticky 1, res_valid 2 cycles after accept.
- R SUB, a=5, b=5 → res_data 0, res_zero 1, res_ovf 0; then I SLT a=0xFFFFFFFF, imm=1 → res_data 1.
- Branch BNE, a=b=0x1234 → res_taken 0; BEQ same operands → res_taken 1; AND producing carry-like pattern → res_ovf 0.
- Illegal (class 11 or R f3=001) → res_illegal 1, res_data 0, op_count increments on handshake.
- Hold res_ready=0 for 3 cycles with cmd_valid=1 → outputs stable, cmd_ready 0. Release → back-to-back accept in the same cycle, next result 2 cycles later. ovf_clear coincident with overflow capture → ovf_sticky stays 1.
- Assert rst during EXEC → all outputs 0 asynchronously, op_count 0, next command processes normally.
